// File: rtl/reg_file_multi_pkg.sv
// Shared definitions for the multi-port register file: default sizes and the
// clear-sequencer state encoding.
package reg_file_multi_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // CLEAR is the reset state, so it is encoded as all-zeros.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer for reg_file_multi: walks every register index once,
// issuing a zero-write per cycle, after reset or on a clear request.
// busy is high for the whole sweep (exactly NREGS cycles).
module reg_file_clr_seq
    import reg_file_multi_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    // State and sweep index registers; reset restarts the sweep from index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state and sweep outputs; clear requests are ignored mid-sweep.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        busy       = 1'b0;
        sweep_we   = 1'b0;
        sweep_addr = clr_idx_q;
        case (state_q)
            RF_CLEAR: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = RF_READY;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            RF_READY: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/reg_file_multi.sv
// Architectural register file: NREGS x XLEN, two combinational read ports,
// one synchronous write port, and a built-in zeroing sweep (reg_file_clr_seq).
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding; without it a read of rd_addr returns the old contents.
module reg_file_multi
    import reg_file_multi_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   rd_addr,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_data,
    input  logic            clr_req,
    output logic            busy,
    output logic            wr_drop
);

    logic [XLEN-1:0] mem_q [NREGS];

    logic            sweep_we;
    logic [AW-1:0]   sweep_addr;
    logic            user_we;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            wr_drop_q;

    logic [AW-1:0]   rs_addr [2];
    logic [XLEN-1:0] rs_data [2];

    // An address is usable when it is inside the file and is not a hardwired x0.
    function automatic logic addr_legal(input logic [AW-1:0] a);
        return !((ZERO_REG != 0) && (a == '0)) && (int'(a) < NREGS);
    endfunction

    reg_file_clr_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // User writes only land when the sweep is idle and the target is legal.
    assign user_we   = wr_en && !busy && addr_legal(rd_addr);
    assign mem_we    = sweep_we || user_we;
    assign mem_addr  = busy ? sweep_addr : rd_addr;
    assign mem_wdata = busy ? '0 : wr_data;

    // Storage array: no reset term, the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    // One-cycle flag for a write that arrived while the sweep owned the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_en && busy;
        end
    end

    assign wr_drop = wr_drop_q;

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        // Read mux: zero while busy or for illegal addresses, else storage/forward.
        always_comb begin
            rs_data[gi] = '0;
            if (!busy && addr_legal(rs_addr[gi])) begin
                rs_data[gi] = mem_q[rs_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                if (user_we && (rs_addr[gi] == rd_addr)) begin
                    rs_data[gi] = wr_data;
                end
`endif
            end
        end
    end

    assign rs1_data = rs_data[0];
    assign rs2_data = rs_data[1];

endmodule

// File: tb/tb_reg_file_multi.sv
// Self-checking bench for reg_file_multi: one instance with 32 registers and
// one with 24, driven from directed sequences then random traffic, compared
// against a behavioural model of the register file.
module tb_reg_file_multi;

    localparam int NREGS_C [2] = '{32, 24};

    logic        clk;
    logic        rst_n    [2];
    logic [4:0]  rs1_addr [2];
    logic [4:0]  rs2_addr [2];
    logic [31:0] rs1_data [2];
    logic [31:0] rs2_data [2];
    logic [4:0]  rd_addr  [2];
    logic        wr_en    [2];
    logic [31:0] wr_data  [2];
    logic        clr_req  [2];
    logic        busy     [2];
    logic        wr_drop  [2];

    // Reference model state
    logic [31:0] m_mem  [2][32];
    int          m_busy [2];
    logic        m_drop [2];

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt [2];

    reg_file_multi #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n[0]),
        .rs1_addr(rs1_addr[0]), .rs2_addr(rs2_addr[0]),
        .rs1_data(rs1_data[0]), .rs2_data(rs2_data[0]),
        .rd_addr(rd_addr[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .clr_req(clr_req[0]), .busy(busy[0]), .wr_drop(wr_drop[0])
    );

    reg_file_multi #(.XLEN(32), .NREGS(24), .ZERO_REG(1)) u_dut24 (
        .clk(clk), .rst_n(rst_n[1]),
        .rs1_addr(rs1_addr[1]), .rs2_addr(rs2_addr[1]),
        .rs1_data(rs1_data[1]), .rs2_data(rs2_data[1]),
        .rd_addr(rd_addr[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .clr_req(clr_req[1]), .busy(busy[1]), .wr_drop(wr_drop[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic legal(input int d, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREGS_C[d]);
    endfunction

    function automatic logic [31:0] exp_read(input int d, input logic [4:0] a);
        if (m_busy[d] > 0 || !legal(d, a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en[d] && legal(d, rd_addr[d]) && a == rd_addr[d]) return wr_data[d];
`endif
        return m_mem[d][a];
    endfunction

    task automatic model_reset(input int d);
        m_busy[d] = NREGS_C[d];
        m_drop[d] = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
    endtask

    // Model behaviour at one rising edge, from the pre-edge inputs.
    task automatic model_edge(input int d);
        if (!rst_n[d]) begin
            model_reset(d);
        end else if (m_busy[d] > 0) begin
            m_drop[d] = wr_en[d];
            m_busy[d]--;
        end else begin
            m_drop[d] = 1'b0;
            if (wr_en[d] && legal(d, rd_addr[d])) m_mem[d][rd_addr[d]] = wr_data[d];
            if (clr_req[d]) begin
                m_busy[d] = NREGS_C[d];
                for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (busy[d]) busy_cnt[d]++;
            chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_busy[d] > 0));
            chk($sformatf("wr_drop%0d", d), 32'(wr_drop[d]), 32'(m_drop[d]));
            chk($sformatf("rs1_%0d[%0d]", d, rs1_addr[d]), rs1_data[d], exp_read(d, rs1_addr[d]));
            chk($sformatf("rs2_%0d[%0d]", d, rs2_addr[d]), rs2_data[d], exp_read(d, rs2_addr[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d] || clr_req[d] || !rst_n[d])
                $display("[%0t] dut%0d rst_n=%0b wr_en=%0b rd=%0d data=%h clr=%0b busy=%0b",
                         $time, d, rst_n[d], wr_en[d], rd_addr[d], wr_data[d], clr_req[d], busy[d]);
            model_edge(d);
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle(input int d);
        wr_en[d] = 1'b0; clr_req[d] = 1'b0; rd_addr[d] = 5'd0;
        wr_data[d] = 32'h0; rs1_addr[d] = 5'd0; rs2_addr[d] = 5'd0;
    endtask

    task automatic write(input int d, input logic [4:0] a, input logic [31:0] v);
        wr_en[d] = 1'b1; rd_addr[d] = a; wr_data[d] = v;
        step();
        wr_en[d] = 1'b0;
    endtask

    task automatic wait_ready(input int d, input int limit);
        int n = 0;
        while (busy[d] && n < limit) begin
            step();
            n++;
        end
        chk($sformatf("ready_wait%0d", d), 32'(busy[d]), 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            idle(d);
            rst_n[d] = 1'b0;
            model_reset(d);
            busy_cnt[d] = 0;
        end
        #1;
        step();
        step();
        // Release reset on both instances and measure the sweep length.
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        repeat (40) step();
        chk("busy_len_reset32", busy_cnt[0], 32);
        chk("busy_len_reset24", busy_cnt[1], 24);

        rs1_addr[0] = 5'd5;
        settle();
        chk("x5_after_reset", rs1_data[0], 32'h0);
        tick();

        // Basic write then dual read of the same register; x0 stays zero.
        write(0, 5'd7, 32'hDEADBEEF);
        rs1_addr[0] = 5'd7; rs2_addr[0] = 5'd7;
        settle();
        chk("x7_rs1", rs1_data[0], 32'hDEADBEEF);
        chk("x7_rs2", rs2_data[0], 32'hDEADBEEF);
        tick();
        write(0, 5'd0, 32'h1234);
        rs1_addr[0] = 5'd0;
        settle();
        chk("x0_zero", rs1_data[0], 32'h0);
        tick();

        // Write during a sweep is dropped and flagged one cycle later.
        write(0, 5'd3, 32'h3333_3333);
        clr_req[0] = 1'b1;
        step();
        clr_req[0] = 1'b0;
        write(0, 5'd3, 32'hCAFE_F00D);
        settle();
        chk("wr_drop_pulse", 32'(wr_drop[0]), 32'h1);
        tick();
        wait_ready(0, 40);
        rs1_addr[0] = 5'd3;
        settle();
        chk("x3_after_drop", rs1_data[0], 32'h0);
        tick();

        // Clear request zeroes contents; a request mid-sweep does not extend it.
        write(0, 5'd9, 32'hA5A5A5A5);
        clr_req[0] = 1'b1;
        step();
        busy_cnt[0] = 0;
        for (int i = 0; i < 40; i++) begin
            clr_req[0] = (i == 10);
            step();
        end
        clr_req[0] = 1'b0;
        chk("busy_len_clr32", busy_cnt[0], 32);
        rs1_addr[0] = 5'd9;
        settle();
        chk("x9_cleared", rs1_data[0], 32'h0);
        tick();

        // Same-cycle write and read of x4.
        write(0, 5'd4, 32'h11);
        wr_en[0] = 1'b1; rd_addr[0] = 5'd4; wr_data[0] = 32'h55; rs1_addr[0] = 5'd4;
        settle();
`ifdef REGFILE_BYPASS_EN
        chk("x4_same_cycle", rs1_data[0], 32'h55);
`else
        chk("x4_same_cycle", rs1_data[0], 32'h11);
`endif
        tick();
        wr_en[0] = 1'b0;
        settle();
        chk("x4_next_cycle", rs1_data[0], 32'h55);
        tick();

        // 24-register instance: out-of-range write ignored, reset mid-sweep.
        write(1, 5'd30, 32'hBAD0_BAD0);
        rs2_addr[1] = 5'd30;
        write(1, 5'd23, 32'h2323_2323);
        rs1_addr[1] = 5'd23;
        settle();
        chk("x30_n24_zero", rs2_data[1], 32'h0);
        chk("x23_n24", rs1_data[1], 32'h2323_2323);
        tick();
        clr_req[1] = 1'b1;
        step();
        clr_req[1] = 1'b0;
        repeat (10) step();
        rst_n[1] = 1'b0;
        model_reset(1);
        step();
        rst_n[1] = 1'b1;
        busy_cnt[1] = 0;
        repeat (30) step();
        chk("busy_len_rst24", busy_cnt[1], 24);

        // Random traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (!rst_n[d]) begin
                    rst_n[d] = 1'b1;
                end else if ($urandom_range(0, 249) == 0) begin
                    rst_n[d] = 1'b0;
                    model_reset(d);
                end
                wr_en[d]    = ($urandom_range(0, 1) == 1);
                rd_addr[d]  = 5'($urandom_range(0, 31));
                wr_data[d]  = $urandom;
                clr_req[d]  = ($urandom_range(0, 59) == 0);
                rs1_addr[d] = ($urandom_range(0, 2) == 0) ? rd_addr[d] : 5'($urandom_range(0, 31));
                rs2_addr[d] = 5'($urandom_range(0, 31));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
